// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALU opcodes and forward-select codes for the MIPS datapath
package mips_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_NOR = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
endpackage

// File: rtl/forward_mux.sv
// forward_mux: resolves one source register against the MEM/WB producers; bypass exists only with ID_EX_FORWARDING_EN
module forward_mux
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_WIDTH-1:0] r,
    input  logic                      mem_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0] mem_writereg,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic                      wb_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0] wb_writereg,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic [DATA_WIDTH-1:0]     value,
    output logic [1:0]                sel,
    output logic [DATA_WIDTH-1:0]     fwd
);
`ifdef ID_EX_FORWARDING_EN
    // MEM is the newer producer so it beats WB; register 0 is hardwired and never bypassed
    always_comb begin
        sel = (mem_regwrite && mem_writereg == r && r != '0) ? FWD_MEM :
              (wb_regwrite && wb_writereg == r && r != '0)   ? FWD_WB  : FWD_NONE;
        fwd = (sel == FWD_MEM) ? mem_result : (sel == FWD_WB) ? wb_data : value;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{r, mem_regwrite, mem_writereg, mem_result, wb_regwrite, wb_writereg, wb_data};
    assign sel = FWD_NONE;
    assign fwd = value;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB operand forwarding (enabled by ID_EX_FORWARDING_EN)
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = mips_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      ID_Valid,
    input  logic [3:0]                ID_ALUOperation,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData1,
    input  logic [DATA_WIDTH-1:0]     ID_ReadData2,
    input  logic [DATA_WIDTH-1:0]     ID_Immediate,
    input  logic                      ID_ALUSrc,
    input  logic [4:0]                ID_Shamt,
    input  logic [REG_ADDR_WIDTH-1:0] ID_Rs,
    input  logic [REG_ADDR_WIDTH-1:0] ID_Rt,
    input  logic [REG_ADDR_WIDTH-1:0] ID_WriteReg,
    input  logic                      ID_RegWrite,
    input  logic                      MEM_RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] MEM_WriteReg,
    input  logic [DATA_WIDTH-1:0]     MEM_ALUResult,
    input  logic                      WB_RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] WB_WriteReg,
    input  logic [DATA_WIDTH-1:0]     WB_WriteData,
    output logic                      EX_Valid,
    output logic [3:0]                EX_ALUOperation,
    output logic [DATA_WIDTH-1:0]     EX_A,
    output logic [DATA_WIDTH-1:0]     EX_B,
    output logic [4:0]                EX_Shamt,
    output logic [DATA_WIDTH-1:0]     EX_StoreData,
    output logic [REG_ADDR_WIDTH-1:0] EX_WriteReg,
    output logic                      EX_RegWrite,
    output logic [1:0]                ForwardA,
    output logic [1:0]                ForwardB
);
    logic                      valid, alusrc, regwrite;
    logic [3:0]                opcode;
    logic [DATA_WIDTH-1:0]     rd1, rd2, imm, fwd_b;
    logic [4:0]                shamt;
    logic [REG_ADDR_WIDTH-1:0] rs, rt, writereg;

    // Bubble on reset or flush (all-zero is opcode AND, invalid, no write); stall holds everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            {valid, opcode, rd1, rd2, imm, alusrc, shamt, rs, rt, writereg, regwrite} <= '0;
        else if (Flush || !Stall)
            {valid, opcode, rd1, rd2, imm, alusrc, shamt, rs, rt, writereg, regwrite} <= Flush ? '0 :
                {ID_Valid, ID_ALUOperation, ID_ReadData1, ID_ReadData2, ID_Immediate, ID_ALUSrc,
                 ID_Shamt, ID_Rs, ID_Rt, ID_WriteReg, ID_RegWrite};
    end

    forward_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .r(rs), .mem_regwrite(MEM_RegWrite), .mem_writereg(MEM_WriteReg), .mem_result(MEM_ALUResult),
        .wb_regwrite(WB_RegWrite), .wb_writereg(WB_WriteReg), .wb_data(WB_WriteData),
        .value(rd1), .sel(ForwardA), .fwd(EX_A)
    );

    forward_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .r(rt), .mem_regwrite(MEM_RegWrite), .mem_writereg(MEM_WriteReg), .mem_result(MEM_ALUResult),
        .wb_regwrite(WB_RegWrite), .wb_writereg(WB_WriteReg), .wb_data(WB_WriteData),
        .value(rd2), .sel(ForwardB), .fwd(fwd_b)
    );

    assign EX_Valid        = valid;
    assign EX_ALUOperation = opcode;
    assign EX_Shamt        = shamt;
    assign EX_WriteReg     = writereg;
    assign EX_RegWrite     = regwrite & valid;
    assign EX_StoreData    = fwd_b;
    assign EX_B            = alusrc ? imm : fwd_b;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table vectors, hand sequences and randomized checks of id_ex_stage against a reference model
module tb_id_ex_stage;
    import mips_pkg::*;
`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic          valid;
        logic [3:0]    op;
        logic [DW-1:0] rd1, rd2, imm;
        logic          alusrc;
        logic [4:0]    shamt;
        logic [AW-1:0] rs, rt, wr;
        logic          regw;
    } instr_t;

    typedef struct {
        logic          mem_rw;
        logic [AW-1:0] mem_wr;
        logic [DW-1:0] mem_res;
        logic          wb_rw;
        logic [AW-1:0] wb_wr;
        logic [DW-1:0] wb_data;
    } src_t;

    typedef struct {
        logic [DW-1:0] a, b, sd;
        logic [1:0]    fa, fb;
    } exp_t;

    typedef struct {
        instr_t i;
        src_t   s;
        exp_t   e;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, Stall = 1'b0, Flush = 1'b0;
    instr_t id, m;
    src_t src;
    logic EX_Valid, EX_RegWrite;
    logic [3:0] EX_ALUOperation;
    logic [DW-1:0] EX_A, EX_B, EX_StoreData;
    logic [4:0] EX_Shamt;
    logic [AW-1:0] EX_WriteReg;
    logic [1:0] ForwardA, ForwardB;
    int checks = 0, errors = 0;
    vec_t tbl[8];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .ID_Valid(id.valid), .ID_ALUOperation(id.op), .ID_ReadData1(id.rd1), .ID_ReadData2(id.rd2),
        .ID_Immediate(id.imm), .ID_ALUSrc(id.alusrc), .ID_Shamt(id.shamt), .ID_Rs(id.rs), .ID_Rt(id.rt),
        .ID_WriteReg(id.wr), .ID_RegWrite(id.regw),
        .MEM_RegWrite(src.mem_rw), .MEM_WriteReg(src.mem_wr), .MEM_ALUResult(src.mem_res),
        .WB_RegWrite(src.wb_rw), .WB_WriteReg(src.wb_wr), .WB_WriteData(src.wb_data),
        .EX_Valid(EX_Valid), .EX_ALUOperation(EX_ALUOperation), .EX_A(EX_A), .EX_B(EX_B),
        .EX_Shamt(EX_Shamt), .EX_StoreData(EX_StoreData), .EX_WriteReg(EX_WriteReg),
        .EX_RegWrite(EX_RegWrite), .ForwardA(ForwardA), .ForwardB(ForwardB)
    );

    function automatic instr_t bubble();
        instr_t b = '{default: '0};
        return b;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.valid  = 1'($urandom_range(0, 1));
        r.op     = 4'($urandom_range(0, 7));
        r.rd1    = $urandom;
        r.rd2    = $urandom;
        r.imm    = $urandom;
        r.alusrc = 1'($urandom_range(0, 1));
        r.shamt  = 5'($urandom);
        r.rs     = AW'($urandom_range(0, 3));
        r.rt     = AW'($urandom_range(0, 3));
        r.wr     = AW'($urandom);
        r.regw   = 1'($urandom_range(0, 1));
        return r;
    endfunction

    // Newest producer wins, register 0 never bypassed; returns {select, value}
    function automatic logic [DW+1:0] resolve(input logic [AW-1:0] r, input logic [DW-1:0] v);
        if (FWD && r != 0 && src.mem_rw && src.mem_wr == r) return {2'b01, src.mem_res};
        if (FWD && r != 0 && src.wb_rw && src.wb_wr == r) return {2'b10, src.wb_data};
        return {2'b00, v};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input instr_t e);
        check({tag, ".valid"}, DW'(EX_Valid), DW'(e.valid));
        check({tag, ".op"}, DW'(EX_ALUOperation), DW'(e.op));
        check({tag, ".shamt"}, DW'(EX_Shamt), DW'(e.shamt));
        check({tag, ".wreg"}, DW'(EX_WriteReg), DW'(e.wr));
        check({tag, ".regwrite"}, DW'(EX_RegWrite), DW'(e.regw & e.valid));
    endtask

    task automatic check_model(input string tag);
        logic [DW+1:0] ra, rb;
        ra = resolve(m.rs, m.rd1);
        rb = resolve(m.rt, m.rd2);
        check_ctrl(tag, m);
        check({tag, ".A"}, EX_A, ra[DW-1:0]);
        check({tag, ".B"}, EX_B, m.alusrc ? m.imm : rb[DW-1:0]);
        check({tag, ".store"}, EX_StoreData, rb[DW-1:0]);
        check({tag, ".fwdA"}, DW'(ForwardA), DW'(ra[DW+1:DW]));
        check({tag, ".fwdB"}, DW'(ForwardB), DW'(rb[DW+1:DW]));
    endtask

    task automatic step(input string tag, input logic st, input logic fl);
        Stall = st;
        Flush = fl;
        @(posedge clk);
        if (fl) m = bubble();
        else if (!st) m = id;
        #1;
        check_model(tag);
    endtask

    initial begin
        tbl[0] = '{'{1, ALU_ADD, 32'h10, 32'h20, 0, 0, 0, 3, 4, 9, 1}, '{0, 0, 0, 0, 0, 0},
                   '{32'h10, 32'h20, 32'h20, 2'b00, 2'b00}};
        tbl[1] = '{'{1, ALU_ADD, 32'h10, 32'h20, 0, 0, 2, 3, 4, 9, 1}, '{1, 3, 32'hAAAA, 1, 3, 32'h5555},
                   '{FWD ? 32'hAAAA : 32'h10, 32'h20, 32'h20, FWD ? 2'b01 : 2'b00, 2'b00}};
        tbl[2] = '{'{1, ALU_SUB, 32'h30, 32'h77, 0, 0, 0, 1, 0, 2, 1}, '{0, 0, 0, 1, 0, 32'hFFFF},
                   '{32'h30, 32'h77, 32'h77, 2'b00, 2'b00}};
        tbl[3] = '{'{1, ALU_ADD, 32'h40, 32'h99, 32'h0000FFFC, 1, 0, 6, 5, 7, 0}, '{1, 5, 32'h1234, 0, 0, 0},
                   '{32'h40, 32'h0000FFFC, FWD ? 32'h1234 : 32'h99, 2'b00, FWD ? 2'b01 : 2'b00}};
        tbl[4] = '{'{1, ALU_SLL, 32'h1, 32'h2, 0, 0, 4, 7, 8, 10, 1}, '{0, 0, 0, 1, 7, 32'hBEEF},
                   '{FWD ? 32'hBEEF : 32'h1, 32'h2, 32'h2, FWD ? 2'b10 : 2'b00, 2'b00}};
        tbl[5] = '{'{1, ALU_OR, 32'h11, 32'h22, 0, 0, 0, 9, 10, 1, 1}, '{0, 9, 32'hDEAD, 1, 9, 32'hCAFE},
                   '{FWD ? 32'hCAFE : 32'h11, 32'h22, 32'h22, FWD ? 2'b10 : 2'b00, 2'b00}};
        tbl[6] = '{'{1, ALU_AND, 32'h11, 32'h22, 0, 0, 31, 12, 13, 14, 1}, '{1, 13, 32'hAB, 1, 12, 32'hCD},
                   '{FWD ? 32'hCD : 32'h11, FWD ? 32'hAB : 32'h22, FWD ? 32'hAB : 32'h22,
                     FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00}};
        tbl[7] = '{'{0, ALU_NOR, 32'h5, 32'h6, 0, 0, 0, 0, 0, 0, 1}, '{1, 0, 32'hF0F0, 1, 0, 32'h0F0F},
                   '{32'h5, 32'h6, 32'h6, 2'b00, 2'b00}};

        id = rand_instr();
        id.valid = 1'b1;
        src = '{default: '0};
        m = bubble();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            id = tbl[k].i;
            src = tbl[k].s;
            Stall = 1'b0;
            Flush = 1'b0;
            @(posedge clk);
            m = id;
            #1;
            check_ctrl($sformatf("vec%0d", k), tbl[k].i);
            check($sformatf("vec%0d.A", k), EX_A, tbl[k].e.a);
            check($sformatf("vec%0d.B", k), EX_B, tbl[k].e.b);
            check($sformatf("vec%0d.store", k), EX_StoreData, tbl[k].e.sd);
            check($sformatf("vec%0d.fwdA", k), DW'(ForwardA), DW'(tbl[k].e.fa));
            check($sformatf("vec%0d.fwdB", k), DW'(ForwardB), DW'(tbl[k].e.fb));
        end

        // asynchronous reset in the middle of a cycle, then first load after release
        @(negedge clk);
        src = '{default: '0};
        id = '{1, ALU_SUB, 32'h55, 32'h66, 0, 0, 3, 2, 3, 4, 1};
        step("preload", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        m = bubble();
        check_model("async_rst");
        check("async_rst.A_zero", EX_A, 32'h0);
        @(negedge clk);
        id = '{1, ALU_LUI, 32'h77, 32'h88, 32'h1234, 1, 0, 5, 6, 8, 1};
        reset = 1'b0;
        #1;
        check_model("rst_release");
        step("first_load", 1'b0, 1'b0);
        check("first_load.B_imm", EX_B, 32'h1234);

        // stall holds registers while forwarding re-resolves against live MEM/WB
        @(negedge clk);
        id = '{1, ALU_ADD, 32'h100, 32'h200, 0, 0, 1, 3, 4, 6, 1};
        step("stall_load", 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            id = rand_instr();
            src = '{1, 3, 32'hA000 + DW'(k), 0, 0, 0};
            step($sformatf("stall%0d", k), 1'b1, 1'b0);
            check($sformatf("stall%0d.op_held", k), DW'(EX_ALUOperation), DW'(ALU_ADD));
        end
        @(negedge clk);
        id = rand_instr();
        step("stall_flush", 1'b1, 1'b1);
        check("stall_flush.valid0", DW'(EX_Valid), 32'h0);

        // randomized traffic with small register numbers to provoke collisions
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            id = rand_instr();
            src.mem_rw = 1'($urandom_range(0, 1));
            src.mem_wr = AW'($urandom_range(0, 3));
            src.mem_res = $urandom;
            src.wb_rw = 1'($urandom_range(0, 1));
            src.wb_wr = AW'($urandom_range(0, 3));
            src.wb_data = $urandom;
            step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
